// File: rtl/ds_pkg.sv
// Shared types and helpers for ds datapath blocks.
package ds_pkg;

   typedef enum logic [1:0] {
      FC_BI,
      FC_UNI,
      FC_NO
   } t_fc;

   typedef enum logic {
      FIFO_ARCH_RAM,
      FIFO_ARCH_SHR
   } t_fifo_arch;

   function automatic int f_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ds_fifo_mem.sv
// ds_fifo storage: circular RAM or shift register selected by P_ARCH.
// Pure storage; all pointer/count bookkeeping lives in ds_fifo.
module ds_fifo_mem
   import ds_pkg::*;
#(
   parameter int         P_WIDTH = 8,
   parameter int         P_DEPTH = 16,
   parameter t_fifo_arch P_ARCH  = FIFO_ARCH_RAM,
   parameter int         P_AW    = $clog2(P_DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_wr,
   input  logic [P_AW-1:0]    i_wr_idx,
   input  logic [P_WIDTH-1:0] i_wr_dat,
   input  logic [P_AW-1:0]    i_rd_idx,
   input  logic               i_shift,
   output logic [P_WIDTH-1:0] o_dat
);

   if (P_ARCH == FIFO_ARCH_RAM) begin : g_ram
      logic [P_WIDTH-1:0] mem [P_DEPTH];
      logic               shift_unused;

      assign shift_unused = i_shift;

      always_ff @(posedge i_clk) begin
         if (i_wr) mem[i_wr_idx] <= i_wr_dat;
      end

      assign o_dat = mem[i_rd_idx];
   end else begin : g_shr
      logic [P_WIDTH-1:0] mem [P_DEPTH];
      logic               rd_unused;

      assign rd_unused = ^i_rd_idx;

      // write index is post-shift, so the later write wins on overlap
      always_ff @(posedge i_clk) begin
         if (i_shift) begin
            for (int i = 0; i < P_DEPTH - 1; i++) mem[i] <= mem[i+1];
         end
         if (i_wr) mem[i_wr_idx] <= i_wr_dat;
      end

      assign o_dat = mem[0];
   end

endmodule

// File: rtl/ds_fifo.sv
// Parametrised FWFT FIFO with selectable storage and input flow control.
// Optional o_lvl/o_afull ports are present only with DS_FIFO_LEVEL_EN defined.
module ds_fifo
   import ds_pkg::*;
#(
   parameter int         P_WIDTH = 8,
   parameter int         P_DEPTH = 16,
   parameter t_fifo_arch P_ARCH  = FIFO_ARCH_RAM,
   parameter t_fc        P_FC    = FC_BI
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [P_WIDTH-1:0] i_dat,
   input  logic               i_vld,
   output logic               o_rdy,
   output logic [P_WIDTH-1:0] o_dat,
   output logic               o_vld,
   input  logic               i_rdy,
   input  logic               i_ovf_clr,
   output logic               o_ovf
`ifdef DS_FIFO_LEVEL_EN
   ,
   output logic [f_cnt_w(P_DEPTH)-1:0] o_lvl,
   output logic                        o_afull
`endif
);

   localparam int CW = f_cnt_w(P_DEPTH);
   localparam int AW = $clog2(P_DEPTH);

   logic [CW-1:0]      cnt, cnt_nxt;
   logic [AW-1:0]      wr_ptr, rd_ptr, wr_idx;
   logic               vld_q, rdy_q, ovf_q;
   logic               full, push_req, push, pop, drop;
   logic [P_WIDTH-1:0] mem_dat;

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full = (cnt == CW'(P_DEPTH));
   assign pop  = vld_q & i_rdy;

   always_comb begin
      push_req = 1'b0;
      case (P_FC)
         FC_BI:   push_req = i_vld & rdy_q;
         FC_UNI:  push_req = i_vld;
         default: push_req = 1'b1;
      endcase
   end

   // FC_BI never requests when full, so the pop bypass only matters otherwise
   assign push = push_req & (~full | pop);
   assign drop = push_req & full & ~pop;

   always_comb begin
      cnt_nxt = cnt;
      if (push & ~pop & ~full)
         cnt_nxt = cnt + 1'b1;
      else if (pop & ~push & (cnt != '0))
         cnt_nxt = cnt - 1'b1;
   end

   assign wr_idx = (P_ARCH == FIFO_ARCH_RAM) ? wr_ptr
                 : AW'(pop ? cnt - 1'b1 : cnt);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         vld_q  <= 1'b0;
         rdy_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         vld_q <= (cnt_nxt != '0);
         rdy_q <= (P_FC == FC_BI) ? (cnt_nxt != CW'(P_DEPTH)) : 1'b1;
         if (push) wr_ptr <= f_inc(wr_ptr);
         if (pop)  rd_ptr <= f_inc(rd_ptr);
         if (drop)
            ovf_q <= 1'b1;
         else if (i_ovf_clr)
            ovf_q <= 1'b0;
      end
   end

   ds_fifo_mem #(
      .P_WIDTH (P_WIDTH),
      .P_DEPTH (P_DEPTH),
      .P_ARCH  (P_ARCH),
      .P_AW    (AW)
   ) u_mem (
      .i_clk    (i_clk),
      .i_wr     (push),
      .i_wr_idx (wr_idx),
      .i_wr_dat (i_dat),
      .i_rd_idx (rd_ptr),
      .i_shift  (pop),
      .o_dat    (mem_dat)
   );

   // masking keeps both archs identical and o_dat at 0 out of reset
   assign o_dat = vld_q ? mem_dat : '0;
   assign o_vld = vld_q;
   assign o_rdy = rdy_q;
   assign o_ovf = ovf_q;

`ifdef DS_FIFO_LEVEL_EN
   assign o_lvl   = cnt;
   assign o_afull = (cnt >= CW'(P_DEPTH - 1));
`endif

endmodule
